// File: rtl/instruction_loader.sv
// instruction_loader: accepts a framed program image (count, count*4 data bytes, XOR checksum)
// as a byte stream, writes it word by word into instruction memory and holds the CPU until done.
module instruction_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_a,
  output logic [31:0]           imem_wd,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [8:0]          MAX_CNT = 9'(2**ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_n;
  logic [ADDR_WIDTH:0]   r_wcnt;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_bidx;
  logic [23:0]           r_shift;
  logic [7:0]            r_csum;
  logic                  r_we;
  logic [31:0]           r_wd;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_last;

  assign rx_ready = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign w_accept = rx_valid && rx_ready;
  assign w_last   = (r_wcnt + (ADDR_WIDTH+1)'(1)) == r_n;

  assign imem_we      = r_we;
  assign imem_a       = r_addr;
  assign imem_wd      = r_wd;
  assign cpu_hold     = r_hold;
  assign done         = r_done;
  assign error        = r_err;
  assign words_loaded = r_words;

  // Loader FSM: frame parsing, word assembly, memory write pulses and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_wcnt  <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_bidx  <= 2'd0;
      r_shift <= 24'd0;
      r_csum  <= 8'd0;
      r_we    <= 1'b0;
      r_wd    <= 32'd0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address and word count advance the cycle after each write pulse; the address
      // holds at the top index instead of wrapping after the last word.
      if (r_we) begin
        if (r_addr != {ADDR_WIDTH{1'b1}}) begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end else begin
          r_addr <= r_addr;
        end
        if (r_words != DEPTH) begin
          r_words <= r_words + (ADDR_WIDTH+1)'(1);
        end else begin
          r_words <= r_words;
        end
      end else begin
        r_addr  <= r_addr;
        r_words <= r_words;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_COUNT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            if ({1'b0, rx_data} > MAX_CNT) begin
              r_err   <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_n     <= (rx_data == 8'd0) ? DEPTH : (ADDR_WIDTH+1)'(rx_data);
              r_csum  <= 8'd0;
              r_words <= '0;
              r_addr  <= '0;
              r_wcnt  <= '0;
              r_bidx  <= 2'd0;
              r_state <= S_DATA;
            end
          end else begin
            r_state <= S_COUNT;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum  <= r_csum ^ rx_data;
            r_shift <= {r_shift[15:0], rx_data};
            r_bidx  <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              r_we   <= 1'b1;
              r_wd   <= {r_shift, rx_data};
              r_wcnt <= r_wcnt + (ADDR_WIDTH+1)'(1);
              // The checksum byte may arrive during the final write pulse.
              if (w_last) begin
                r_state <= S_CHECK;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_state <= S_DATA;
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            if (rx_data == r_csum) begin
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERROR;
            end
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
            r_state <= S_COUNT;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_hold  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: expected memory writes are queued as frames are sent
// and compared by a monitor as the write pulses appear.
module tb_instruction_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [5:0]  imem_a;
  logic [31:0] imem_wd;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  logic prev_we = 1'b0;
  logic [37:0] exp_q[$];
  logic [7:0]  basic[10];

  instruction_loader #(.ADDR_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_a(imem_a), .imem_wd(imem_wd),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we) begin
      n_writes++;
      chk("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {26'd0, imem_a, imem_wd}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("write_addr_data", {26'd0, imem_a, imem_wd}, {26'd0, exp_q.pop_front()});
      end
    end
    prev_we = imem_we;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_ready_timeout", 64'(t), 64'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_basic();
    exp_q.push_back({6'd0, 32'h2002_0005});
    exp_q.push_back({6'd1, 32'h2003_000c});
  endtask

  initial begin
    basic = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0c, 8'h08};
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_a", 64'(imem_a), 64'd0);
    chk("rst_wd", 64'(imem_wd), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic load, back-to-back bytes
    pulse_start();
    chk("count_ready", 64'(rx_ready), 64'd1);
    push_basic();
    for (int i = 0; i < 10; i++) send(basic[i], 0);
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_hold", 64'(cpu_hold), 64'd0);
    chk("basic_error", 64'(error), 64'd0);
    chk("basic_words", 64'(words_loaded), 64'd2);
    chk("basic_ready", 64'(rx_ready), 64'd0);
    chk("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Checksum error, started from DONE
    pulse_start();
    chk("rearm_done", 64'(done), 64'd0);
    chk("rearm_hold", 64'(cpu_hold), 64'd1);
    push_basic();
    for (int i = 0; i < 9; i++) send(basic[i], 0);
    send(8'h09, 0);
    chk("csum_error", 64'(error), 64'd1);
    chk("csum_done", 64'(done), 64'd0);
    chk("csum_hold", 64'(cpu_hold), 64'd1);
    chk("csum_words", 64'(words_loaded), 64'd2);
    chk("csum_q_empty", 64'(exp_q.size()), 64'd0);

    // Count 0 means 64 words; data = index, XOR of all bytes is 0
    pulse_start();
    chk("err_cleared", 64'(error), 64'd0);
    begin
      int w0;
      w0 = n_writes;
      send(8'h00, 0);
      for (int w = 0; w < 64; w++) begin
        exp_q.push_back({6'(w), 32'(w)});
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'(w), 0);
      end
      send(8'h00, 1);
      chk("full_writes", 64'(n_writes - w0), 64'd64);
    end
    chk("full_done", 64'(done), 64'd1);
    chk("full_words", 64'(words_loaded), 64'd64);
    chk("full_last_a", 64'(imem_a), 64'd63);
    chk("full_q_empty", 64'(exp_q.size()), 64'd0);

    // Illegal count 0x41
    pulse_start();
    begin
      int w0;
      w0 = n_writes;
      send(8'h41, 0);
      chk("illegal_error", 64'(error), 64'd1);
      chk("illegal_ready", 64'(rx_ready), 64'd0);
      rx_data  = 8'h20;
      rx_valid = 1'b1;
      repeat (4) @(negedge clk);
      chk("illegal_ready_held", 64'(rx_ready), 64'd0);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("illegal_no_write", 64'(n_writes - w0), 64'd0);
      chk("illegal_hold", 64'(cpu_hold), 64'd1);
    end

    // Throttled bytes with a start pulse mid-DATA
    pulse_start();
    push_basic();
    for (int i = 0; i < 10; i++) begin
      send(basic[i], 1);
      if (i == 3) pulse_start();
    end
    chk("throttle_done", 64'(done), 64'd1);
    chk("throttle_error", 64'(error), 64'd0);
    chk("throttle_words", 64'(words_loaded), 64'd2);
    chk("throttle_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of word 1
    pulse_start();
    exp_q.push_back({6'd0, 32'h2002_0005});
    for (int i = 0; i < 6; i++) send(basic[i], 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_hold", 64'(cpu_hold), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_words", 64'(words_loaded), 64'd0);
    chk("midrst_a", 64'(imem_a), 64'd0);
    chk("midrst_ready", 64'(rx_ready), 64'd0);
    chk("midrst_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    push_basic();
    for (int i = 0; i < 10; i++) send(basic[i], 0);
    chk("rearm_load_done", 64'(done), 64'd1);
    chk("rearm_load_words", 64'(words_loaded), 64'd2);
    pulse_start();
    chk("final_rearm_done", 64'(done), 64'd0);
    chk("final_rearm_hold", 64'(cpu_hold), 64'd1);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
